alarm_ring_ctrl: RTL

Downstream consumer of the alarm-setting stage: latches the BCD alarm time handed over on that stage's `finish2` pulse, compares it against the running clock time, and drives the ring output and LED blink pattern. Supports dismiss, auto-stop after a fixed ring duration, and limited snooze with BCD time arithmetic. Sits between the alarm-set service, the timekeeping block (`cur_time`, `sec_tick`) and the board outputs.

---
 rtl/alarm_ring_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring controller: holds a BCD alarm, detects the time match, rings with snooze/dismiss/auto-stop.
// Latency: finish2/trigger/dismiss/snooze take effect on outputs one cycle after the causing input.
// Backpressure: none; inputs are single-cycle pulses or levels and are always accepted.
module alarm_ring_ctrl #(
  parameter int unsigned RING_SECS  = 60,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        finish2,
  input  logic [15:0] alarm,
  input  logic [15:0] cur_time,
  input  logic        sec_tick,
  input  logic        spdt_en,
  input  logic        push_c,
  input  logic        push_d,
  output logic        ring,
  output logic [15:0] led,
  output logic        armed,
  output logic [1:0]  snooze_cnt
);

  localparam logic [6:0] SNZ_MIN  = 7'(SNOOZE_MIN);
  localparam logic [7:0] RING_LIM = 8'(RING_SECS);
  localparam logic [1:0] SNZ_MAX  = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {IDLE, ARMED, RINGING} state_t;

  state_t      state, state_n;
  logic [15:0] alarm_reg, alarm_reg_n;
  logic [15:0] target, target_n;
  logic [15:0] led_n;
  logic [7:0]  ring_cnt, ring_cnt_n;
  logic [1:0]  snz_n;
  logic        eq_d;
  logic        eq, trigger, alarm_ok;

  // Adds the snooze interval to a BCD HH:MM value, wrapping at 24:00.
  function automatic logic [15:0] bcd_add_min(input logic [15:0] t);
    logic [6:0] m;
    logic [4:0] h;
    m = {3'b000, t[7:4]} * 7'd10 + {3'b000, t[3:0]} + SNZ_MIN;
    h = {1'b0, t[15:12]} * 5'd10 + {1'b0, t[11:8]};
    if (m >= 7'd60) begin
      m = m - 7'd60;
      h = h + 5'd1;
    end
    if (h >= 5'd24) h = h - 5'd24;
    return {4'(h / 5'd10), 4'(h % 5'd10), 4'(m / 7'd10), 4'(m % 7'd10)};
  endfunction

  assign alarm_ok = (alarm[15:12] <= 4'd2) && (alarm[11:8] <= 4'd9) &&
                    (alarm[7:4] <= 4'd5) && (alarm[3:0] <= 4'd9) &&
                    !((alarm[15:12] == 4'd2) && (alarm[11:8] > 4'd3));
  assign eq      = (cur_time == target);
  assign trigger = eq && !eq_d && spdt_en;

  assign ring  = (state == RINGING);
  assign armed = (state != IDLE);

  // Next-state logic: load, trigger, and ringing exits in priority order.
  always_comb begin
    state_n     = state;
    alarm_reg_n = alarm_reg;
    target_n    = target;
    led_n       = led;
    ring_cnt_n  = ring_cnt;
    snz_n       = snooze_cnt;
    if (finish2 && alarm_ok) begin
      alarm_reg_n = alarm;
      target_n    = alarm;
      snz_n       = 2'd0;
      led_n       = 16'h0000;
      state_n     = ARMED;
    end else begin
      case (state)
        ARMED: begin
          if (trigger) begin
            state_n    = RINGING;
            ring_cnt_n = 8'd0;
            led_n      = 16'hFFFF;
          end
        end
        RINGING: begin
          if (!spdt_en || push_c ||
              (sec_tick && !(push_d && snooze_cnt < SNZ_MAX) && (ring_cnt + 8'd1 == RING_LIM))) begin
            // Dismiss: back to the original alarm time.
            target_n = alarm_reg;
            snz_n    = 2'd0;
            led_n    = 16'h0000;
            state_n  = ARMED;
          end else if (push_d && snooze_cnt < SNZ_MAX) begin
            target_n = bcd_add_min(target);
            snz_n    = snooze_cnt + 2'd1;
            led_n    = 16'h0000;
            state_n  = ARMED;
          end else if (sec_tick) begin
            led_n      = ~led;
            ring_cnt_n = ring_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers; eq_d tracks the match against the target in force next cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      alarm_reg  <= 16'h0000;
      target     <= 16'h0000;
      led        <= 16'h0000;
      ring_cnt   <= 8'd0;
      snooze_cnt <= 2'd0;
      eq_d       <= 1'b0;
    end else begin
      state      <= state_n;
      alarm_reg  <= alarm_reg_n;
      target     <= target_n;
      led        <= led_n;
      ring_cnt   <= ring_cnt_n;
      snooze_cnt <= snz_n;
      eq_d       <= (cur_time == target_n);
    end
  end

endmodule
